seg7_scan_4digit: RTL and testbench
===================================

Name: seg7_scan_4digit

Overview:
- Downstream display stage for the team's BCD counters. Takes four 4-bit BCD digits plus decimal points and time-multiplexes them onto the shared active-low segment bus LED[7:0] and the digit-select lines SA[3:0] of the 4-digit board display.
- Holds a frame-coherent copy of the digits, so a counter update never produces a torn frame.
- Supports leading-zero blanking and an all-off guard interval between digits to suppress ghosting.

Parameters:
- SCAN_DIV, 6000, CLK cycles per digit slot (6 MHz CLK -> 1 kHz per digit, 250 Hz frame); legal range >= 4.
- GUARD_CYCLES, 60, all-off cycles at the start of each slot; legal range 1 .. SCAN_DIV-2.

Ports:
- CLK     input   1   system clock, 6 MHz.
- RESET   input   1   asynchronous, active-low reset.
- DIGITS  input   16  BCD digits: [3:0] = digit0 (rightmost) ... [15:12] = digit3 (leftmost).
- DP      input   4   decimal point request per digit, 1 = lit; bit n is digit n.
- LOAD    input   1   1-cycle strobe; captures DIGITS/DP into the shadow register.
- LZ_EN   input   1   1 = blank leading zeros on digits 3..1.
- LED     output  8   segments {A,B,C,D,E,F,G,Dp}, bit7 = A, bit0 = Dp; 0 = lit.
- SA      output  4   digit select; the active digit drives 0, unselected digits are high-Z.
- FRAME   output  1   1-cycle pulse on the first cycle of digit-0 slot.

Behaviour:
- Reset (RESET=0, async):
  - slot counter = 0, digit index = 0, state = GUARD.
  - shadow and display registers = 0 (digits 0, DP 0).
  - LED = 8'hFF, SA = 4'bzzzz, FRAME = 0.
- Release: the first post-reset slot is digit 0. FRAME pulses on the first rising edge after release.
- Slot counter: counts 0..SCAN_DIV-1 and wraps to 0. At each wrap the digit index advances 0->1->2->3->0.
- State machine, per slot:
  - GUARD while counter < GUARD_CYCLES: LED = 8'hFF, SA = 4'bzzzz.
  - ON while counter >= GUARD_CYCLES: SA[idx] = 0, all other SA bits Z, LED = decoded pattern for digit idx.
  - GUARD -> ON when counter reaches GUARD_CYCLES. ON -> GUARD at counter wrap.
- All outputs are registered: LED, SA and FRAME change only on CLK edges, with 1 cycle of latency from the counter/index/state.
- LOAD: shadow <= {DIGITS, DP} on any cycle LOAD=1. Back-to-back LOADs keep the last value.
- Display register: display <= shadow on the cycle the counter wraps into digit-0 slot. A frame therefore always shows one consistent value. LOAD-to-visible latency is at most 4*SCAN_DIV+1 cycles.
- If LOAD coincides with the frame-boundary transfer, the pre-LOAD shadow is transferred; the new value appears one frame later.
- Decode, segment bits A..G (0 = on), Dp = ~DP[idx]:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001101, 8 = 0000000, 9 = 0000100
  - 10..15 = 0110000 ("E")
- Leading-zero blanking, when LZ_EN=1:
  - Digit n (n = 3..1) is blanked if it and all higher digits are 0. Blanked means segments A..G = 1111111; its Dp is still driven from DP.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the display register, not the shadow.
- FRAME pulses exactly once per 4*SCAN_DIV cycles.

Test Plan:
- Bench parameters for all scenarios: SCAN_DIV=8, GUARD_CYCLES=2.
- Reset/idle: hold RESET=0 for 5 cycles, then release -> LED=8'hFF and SA=zzzz during reset. FRAME pulses on the first edge after release. SA=zzz0 from cycle 3 to cycle 8 after release. SA=zz0z in the next slot.
- Load coherence: LOAD with DIGITS=16'h1234, DP=4'b0000 -> once loaded, each frame shows digit0 LED=8'b1001100_1 ("4") and digit3 LED=8'b1001111_1 ("1"). A second LOAD of 16'h5678 mid-frame does not change digits until the next FRAME.
- Leading-zero blanking: DIGITS=16'h0070, LZ_EN=1 -> digit3 and digit2 show 8'b1111111_1; digit1 shows "7" (8'b0001101_1); digit0 shows "0". With LZ_EN=0, digits 3 and 2 show "0".
- Invalid BCD and DP: DIGITS=16'h00A0, DP=4'b0010, LZ_EN=0 -> digit1 LED=8'b0110000_0; the other digits show "0" with Dp=1.
- Reset mid-slot: assert RESET at counter=5 of the digit-2 slot -> LED=8'hFF and SA=zzzz asynchronously, before the next edge. After release: digit 0 first, display=0.
- Wrap/timing: run 3 full frames -> FRAME period is exactly 32 cycles. Each digit is ON for exactly 6 cycles per slot, and no two SA bits are ever 0 simultaneously.

Source files
------------

// File: rtl/seg7_scan_4digit.sv
// Scans four frame-coherent BCD digits onto an active-low 7-seg bus with guard gaps.
// LED/SA/FRAME registered 1 cycle behind scan state; no backpressure, LOAD always accepted.
module seg7_scan_4digit #(
  parameter int SCAN_DIV     = 6000,
  parameter int GUARD_CYCLES = 60
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] DIGITS,
  input  logic [3:0]  DP,
  input  logic        LOAD,
  input  logic        LZ_EN,
  output logic [7:0]  LED,
  output logic [3:0]  SA,
  output logic        FRAME
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_GLAST = CW'(GUARD_CYCLES - 1);

  typedef enum logic {S_GUARD, S_ON} state_t;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
  } disp_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  disp_t         r_shadow;
  disp_t         r_disp;
  logic [7:0]    r_led;
  logic [3:0]    r_sel;
  logic          r_frame;

  logic          w_wrap;
  logic [3:0]    w_zero;
  logic [3:0]    w_blank;
  logic [3:0]    w_dig;
  logic [6:0]    w_seg;
  logic [7:0]    w_led_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'b0000001;
      4'd1:    bcd_to_seg = 7'b1001111;
      4'd2:    bcd_to_seg = 7'b0010010;
      4'd3:    bcd_to_seg = 7'b0000110;
      4'd4:    bcd_to_seg = 7'b1001100;
      4'd5:    bcd_to_seg = 7'b0100100;
      4'd6:    bcd_to_seg = 7'b0100000;
      4'd7:    bcd_to_seg = 7'b0001101;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0000100;
      default: bcd_to_seg = 7'b0110000;
    endcase
  endfunction

  assign w_wrap = (r_cnt == C_LAST);

  // A digit is a leading zero only if every digit to its left is also zero.
  assign w_zero  = {r_disp.digits[15:12] == 4'd0, r_disp.digits[11:8] == 4'd0,
                    r_disp.digits[7:4] == 4'd0,   r_disp.digits[3:0] == 4'd0};
  assign w_blank = {LZ_EN & w_zero[3], LZ_EN & (&w_zero[3:2]), LZ_EN & (&w_zero[3:1]), 1'b0};

  always_comb begin
    w_dig     = r_disp.digits[{r_idx, 2'b00} +: 4];
    w_seg     = w_blank[r_idx] ? 7'b1111111 : bcd_to_seg(w_dig);
    w_led_nxt = {w_seg, ~r_disp.dp[r_idx]};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_state  <= S_GUARD;
      r_shadow <= '0;
      r_disp   <= '0;
      r_led    <= 8'hFF;
      r_sel    <= 4'b0000;
      r_frame  <= 1'b0;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      r_frame <= (r_cnt == '0) && (r_idx == 2'd0);
      if (w_wrap) r_idx <= r_idx + 2'd1;
      if (LOAD) r_shadow <= {DIGITS, DP};
      // Transfer before this edge's LOAD lands, so a coincident LOAD waits a frame.
      if (w_wrap && (r_idx == 2'd3)) r_disp <= r_shadow;
      case (r_state)
        S_GUARD: begin
          r_led <= 8'hFF;
          r_sel <= 4'b0000;
          if (r_cnt == C_GLAST) r_state <= S_ON;
        end
        S_ON: begin
          r_led <= w_led_nxt;
          r_sel <= 4'b0001 << r_idx;
          if (w_wrap) r_state <= S_GUARD;
        end
        default: r_state <= S_GUARD;
      endcase
    end
  end

  assign LED   = r_led;
  assign FRAME = r_frame;
  assign SA    = {r_sel[3] ? 1'b0 : 1'bz, r_sel[2] ? 1'b0 : 1'bz,
                  r_sel[1] ? 1'b0 : 1'bz, r_sel[0] ? 1'b0 : 1'bz};

endmodule

// File: tb/tb_seg7_scan_4digit.sv
// Bench for seg7_scan_4digit with SCAN_DIV=8, GUARD_CYCLES=2; SA lines pulled up like the board.
module tb_seg7_scan_4digit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        load;
  logic        lz_en;
  wire  [7:0]  led;
  wire  [3:0]  sa;
  wire         frame;

  pullup pu0 (sa[0]);
  pullup pu1 (sa[1]);
  pullup pu2 (sa[2]);
  pullup pu3 (sa[3]);

  seg7_scan_4digit #(.SCAN_DIV(8), .GUARD_CYCLES(2)) dut (
    .CLK(clk), .RESET(rst_n), .DIGITS(digits), .DP(dp), .LOAD(load),
    .LZ_EN(lz_en), .LED(led), .SA(sa), .FRAME(frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sa;
    logic [7:0] led;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_frame = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame) begin
        seen = 1'b1;
        if (last_frame >= 0) chk("frame_period", cyc - last_frame, 32);
        last_frame = cyc;
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_timeout: no FRAME within 100 cycles, required a pulse (cycle %0d)", cyc);
    end
  endtask

  task automatic push_frame(input logic [7:0] l0, input logic [7:0] l1,
                            input logic [7:0] l2, input logic [7:0] l3);
    sb_q.push_back({4'b1110, l0});
    sb_q.push_back({4'b1101, l1});
    sb_q.push_back({4'b1011, l2});
    sb_q.push_back({4'b0111, l3});
  endtask

  task automatic frame_expect(input logic [7:0] l0, input logic [7:0] l1,
                              input logic [7:0] l2, input logic [7:0] l3);
    wait_frame();
    push_frame(l0, l1, l2, l3);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits = d;
    dp     = p;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Monitor: each ON slot pops one expected {SA, LED}; checks guards and slot length.
  bit   prev_on = 1'b0;
  bit   prev_frame = 1'b0;
  bit   on;
  int   run = 0;
  exp_t cur = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_on    = 1'b0;
      prev_frame = 1'b0;
      run        = 0;
    end else begin
      on = (sa != 4'b1111);
      if (frame && prev_frame) chk("frame_width", 2, 1);
      prev_frame = frame;
      if (on) begin
        chk("sa_onehot", $countones(~sa), 1);
        if (!prev_on) begin
          run = 1;
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_underflow: DUT lit SA=0x%0h LED=0x%0h, required no slot (cycle %0d)", sa, led, cyc);
          end else begin
            cur = sb_q.pop_front();
          end
        end else begin
          run++;
        end
        chk("slot_sa", sa, cur.sa);
        chk("slot_led", led, cur.led);
      end else begin
        chk("guard_led", led, 8'hFF);
        if (prev_on) chk("on_len", run, 6);
      end
      prev_on = on;
    end
  end

  initial begin
    logic [3:0] exp_sa;
    rst_n  = 1'b0;
    digits = 16'h0000;
    dp     = 4'b0000;
    load   = 1'b0;
    lz_en  = 1'b0;

    repeat (5) @(negedge clk);
    chk("rst_led", led, 8'hFF);
    chk("rst_sa", sa, 4'b1111);
    chk("rst_frame", frame, 0);
    rst_n = 1'b1;

    // Slot timing right after release: digit 0 lit after edges 3..8, digit 1 after 11..16.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("frame_first", frame, 1);
        last_frame = cyc;
        push_frame(8'h03, 8'h03, 8'h03, 8'h03);
      end
      exp_sa = (k >= 3 && k <= 8) ? 4'b1110 : (k >= 11 && k <= 16) ? 4'b1101 : 4'b1111;
      chk("scan_sa", sa, exp_sa);
    end

    do_load(16'h1234, 4'b0000);
    frame_expect(8'h99, 8'h0D, 8'h25, 8'h9F);

    // Mid-frame LOAD must not disturb the frame in progress.
    repeat (10) @(negedge clk);
    do_load(16'h5678, 4'b0000);
    frame_expect(8'h01, 8'h1B, 8'h41, 8'h49);

    // LOAD on the very edge of the frame transfer: visible one frame later.
    repeat (30) @(negedge clk);
    lz_en = 1'b1;
    do_load(16'h0070, 4'b0000);
    frame_expect(8'h01, 8'h1B, 8'h41, 8'h49);
    frame_expect(8'h03, 8'h1B, 8'hFF, 8'hFF);
    frame_expect(8'h03, 8'h1B, 8'h03, 8'h03);
    lz_en = 1'b0;

    repeat (5) @(negedge clk);
    do_load(16'h00A0, 4'b0010);
    frame_expect(8'h03, 8'h60, 8'h03, 8'h03);
    frame_expect(8'h03, 8'h60, 8'h03, 8'h03);

    // Reset at counter=5 of the digit-2 slot, checked before the next edge.
    repeat (20) @(negedge clk);
    chk("pre_rst_sa", sa, 4'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_led", led, 8'hFF);
    chk("amid_sa", sa, 4'b1111);
    chk("amid_frame", frame, 0);
    sb_q.delete();
    last_frame = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frame_expect(8'h03, 8'h03, 8'h03, 8'h03);
    frame_expect(8'h03, 8'h03, 8'h03, 8'h03);

    repeat (31) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
